ysyx_22041207_hazard_ctrl: RTL

- Pipeline hazard/control unit for the 5-stage RV64 core; drives the hold/clear/flush inputs of the IF/ID, ID/EX and EX/MEM stage registers.
- Detects three conditions:
  - load-use data hazards between ID and EX;
  - control redirects resolved in EX (branch/jal/jalr/trap/mret);
  - multi-cycle LSU waits.
- Also serialises CSR/system instructions by draining the pipeline before they leave ID.
- Sits beside ID; consumes ID-stage decode fields and the ID/EX register outputs.

---
 rtl/ysyx_22041207_pipe_defs_pkg.sv | 23 ++
 rtl/ysyx_22041207_sat_counter.sv | 32 +++
 rtl/ysyx_22041207_hazard_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041207_pipe_defs_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_pipe_defs
// Shared pipeline-control definitions for the 5-stage RV64 core.
//   - Hazard-controller state encoding (RUN / MEM_WAIT / CSR_DRAIN).
//   - Default number of bubble cycles a CSR/system instruction waits in ID.
//   - Helper that turns a drain length into the drain counter's start value.
// ---------------------------------------------------------------------------
package ysyx_22041207_pipe_defs;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT  = 2'd1;
    localparam logic [1:0] ST_CSR_DRAIN = 2'd2;

    localparam int DEF_DRAIN_CYCLES = 3;
    localparam int DRAIN_CNT_W      = 3;

    // The counter is loaded on the first stall cycle, which already counts
    // as one of the drain cycles, so it starts one below the drain length.
    function automatic logic [DRAIN_CNT_W-1:0] drain_start(input int cycles);
        return DRAIN_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ysyx_22041207_sat_counter.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_sat_counter
// Saturating up-counter, updated on the falling clock edge (the edge the
// pipeline stage registers use). Sticks at all-ones instead of wrapping.
// Ports:
//   clk    : core clock (state changes on negedge)
//   rst_n  : asynchronous active-low reset, clears the count
//   i_en   : count this cycle
//   o_cnt  : current count
// ---------------------------------------------------------------------------
module ysyx_22041207_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_22041207_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_hazard_ctrl
// Hazard/control unit for the 5-stage RV64 pipeline. Generates hold, clear
// and flush controls for the IF/ID, ID/EX and EX/MEM stage registers from:
//   - load-use hazards between ID and a load in EX,
//   - control redirects resolved in EX,
//   - multi-cycle LSU waits,
//   - CSR/system instructions, which are held in ID until older ones retire.
// Ports:
//   clk, rst_n                    : clock (negedge updates), async active-low reset
//   id_rs1addr/id_rs2addr         : source registers of the ID instruction
//   id_use_rs1/id_use_rs2         : ID instruction actually reads rs1/rs2
//   id_csr                        : ID instruction needs serialisation
//   ex_rwaddr/ex_writeRD          : destination of the EX instruction
//   ex_memoryReadWen              : EX instruction is a load
//   ex_redirect                   : EX resolved a taken redirect this cycle
//   mem_req_valid/mem_req_ready   : LSU handshake in MEM
//   pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_clear, idex_flush,
//   exmem_stall                   : stage-register controls (combinational)
//   stall_cnt                     : saturating count of PC-stall cycles
// ---------------------------------------------------------------------------
module ysyx_22041207_hazard_ctrl
    import ysyx_22041207_pipe_defs::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1addr,
    input  logic [4:0]       id_rs2addr,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_csr,
    input  logic [4:0]       ex_rwaddr,
    input  logic             ex_writeRD,
    input  logic             ex_memoryReadWen,
    input  logic             ex_redirect,
    input  logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_clear,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = drain_start(DRAIN_CYCLES);

    logic [1:0]             r_state;
    logic [1:0]             r_ret_state;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;

    logic [1:0]             w_nxt_state;
    logic [1:0]             w_nxt_ret_state;
    logic [DRAIN_CNT_W-1:0] w_nxt_drain_cnt;
    logic [1:0]             w_eff_state;
    logic                   w_load_use;
    logic                   w_mem_wait;
    logic                   w_pc_stall;
    logic                   w_ifid_stall;
    logic                   w_ifid_flush;
    logic                   w_idex_bubble;
    logic                   w_idex_clear;
    logic                   w_idex_flush;
    logic                   w_exmem_stall;

    assign w_load_use = ex_memoryReadWen & ex_writeRD & (ex_rwaddr != 5'd0) &
                        ((id_use_rs1 & (id_rs1addr == ex_rwaddr)) |
                         (id_use_rs2 & (id_rs2addr == ex_rwaddr)));

    assign w_mem_wait = mem_req_valid & ~mem_req_ready;

    // Once the LSU completes, the cycle is handled as if we were already
    // back in the saved state, so a held redirect or a paused drain acts
    // on the exit cycle itself.
    assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

    always_comb begin
        w_nxt_state     = w_eff_state;
        w_nxt_ret_state = r_ret_state;
        w_nxt_drain_cnt = r_drain_cnt;
        w_pc_stall      = 1'b0;
        w_ifid_stall    = 1'b0;
        w_ifid_flush    = 1'b0;
        w_idex_bubble   = 1'b0;
        w_idex_clear    = 1'b0;
        w_idex_flush    = 1'b0;
        w_exmem_stall   = 1'b0;

        if (w_mem_wait) begin
            // Whole front of the pipe freezes; drain count is kept as-is.
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_bubble = 1'b1;
            w_exmem_stall = 1'b1;
            w_nxt_state   = ST_MEM_WAIT;
            if (r_state != ST_MEM_WAIT) begin
                w_nxt_ret_state = r_state;
            end
        end else if (ex_redirect) begin
            // The ID instruction (including a draining CSR op) is squashed.
            w_ifid_flush    = 1'b1;
            w_idex_flush    = 1'b1;
            w_nxt_state     = ST_RUN;
            w_nxt_ret_state = ST_RUN;
            w_nxt_drain_cnt = '0;
        end else if (w_eff_state == ST_CSR_DRAIN) begin
            w_nxt_ret_state = ST_RUN;
            if (r_drain_cnt == '0) begin
                w_nxt_state = ST_RUN;
            end else begin
                w_pc_stall      = 1'b1;
                w_ifid_stall    = 1'b1;
                w_idex_clear    = 1'b1;
                w_nxt_drain_cnt = r_drain_cnt - DRAIN_CNT_W'(1);
            end
        end else if (id_csr) begin
            w_pc_stall      = 1'b1;
            w_ifid_stall    = 1'b1;
            w_idex_clear    = 1'b1;
            w_nxt_state     = ST_CSR_DRAIN;
            w_nxt_ret_state = ST_RUN;
            w_nxt_drain_cnt = DRAIN_LAST;
        end else begin
            w_nxt_ret_state = ST_RUN;
            if (w_load_use) begin
                w_pc_stall   = 1'b1;
                w_ifid_stall = 1'b1;
                w_idex_clear = 1'b1;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_ret_state <= w_nxt_ret_state;
            r_drain_cnt <= w_nxt_drain_cnt;
        end
    end

    // Controls are forced low while reset is asserted so the stage
    // registers see a quiet pipe immediately, not at the next edge.
    assign pc_stall    = rst_n & w_pc_stall;
    assign ifid_stall  = rst_n & w_ifid_stall;
    assign ifid_flush  = rst_n & w_ifid_flush;
    assign idex_bubble = rst_n & w_idex_bubble;
    assign idex_clear  = rst_n & w_idex_clear;
    assign idex_flush  = rst_n & w_idex_flush;
    assign exmem_stall = rst_n & w_exmem_stall;

    ysyx_22041207_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_pc_stall),
        .o_cnt (stall_cnt)
    );

`ifndef SYNTHESIS
    a_bubble_clear_excl: assert property (@(negedge clk) disable iff (!rst_n)
        !(idex_bubble && idex_clear));
    a_flush_no_stall: assert property (@(negedge clk) disable iff (!rst_n)
        idex_flush |-> !pc_stall);
    a_drain_cnt_range: assert property (@(negedge clk) disable iff (!rst_n)
        r_drain_cnt <= DRAIN_LAST);
`endif

endmodule
